// File: rtl/store_buffer_drain.sv
// Drains the oldest store-buffer entry into the dcache one store at a time.
// Drains start when loads leave the cache idle long enough, or at once when the buffer is full.
package store_buffer_drain_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byte_en;
    } store_buffer_t;
endpackage

module store_buffer_drain
    import store_buffer_drain_pkg::*;
#(
    parameter int unsigned DRAIN_IDLE_CYCLES = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sb_empty,
    input  logic          sb_full,
    output logic          sb_get_oldest,
    input  store_buffer_t sb_oldest_info,
    input  logic          ld_req_valid,
    output logic          wr_req_valid,
    output store_buffer_t wr_req_info,
    input  logic          wr_req_ready,
    input  logic          wr_rsp_valid,
    input  logic          wr_rsp_miss,
    input  logic          fill_done,
    output logic          drain_busy,
    output logic [15:0]   drain_count
);

    localparam logic [3:0] IDLE_LIMIT = 4'(DRAIN_IDLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        WAIT_FILL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    idle_cnt;
    store_buffer_t hold;
    logic [15:0]   count;
    logic          start;

    // Reset is folded in so a start can never fire in a reset cycle.
    assign start = (state == IDLE) && !reset && !sb_empty &&
                   (sb_full || (!ld_req_valid && (idle_cnt >= IDLE_LIMIT)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            idle_cnt <= 4'd0;
            hold     <= '0;
            count    <= 16'd0;
        end else begin
            state <= state_next;
            if (ld_req_valid) begin
                idle_cnt <= 4'd0;
            end else if (idle_cnt < IDLE_LIMIT) begin
                idle_cnt <= idle_cnt + 4'd1;
            end
            if (start) begin
                hold <= sb_oldest_info;
            end
            if ((state == WAIT_RSP) && wr_rsp_valid && !wr_rsp_miss) begin
                count <= count + 16'd1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        sb_get_oldest = 1'b0;
        wr_req_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sb_get_oldest = 1'b1;
                    state_next    = REQ;
                end
            end
            REQ: begin
                wr_req_valid = 1'b1;
                if (wr_req_ready) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (wr_rsp_valid) begin
                    state_next = wr_rsp_miss ? WAIT_FILL : IDLE;
                end
            end
            WAIT_FILL: begin
                // The held entry is replayed unchanged once the line is present.
                if (fill_done) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_req_info = hold;
    assign drain_busy  = (state != IDLE);
    assign drain_count = count;

endmodule

// File: tb/tb_store_buffer_drain.sv
// Randomized bench for store_buffer_drain: a store-buffer/dcache environment drives the DUT,
// a negedge monitor compares it against a transaction-level model and an in-order store scoreboard.
`timescale 1ns/1ps
module tb_store_buffer_drain;
    import store_buffer_drain_pkg::*;

    localparam int IDLE_N = 4;
    localparam int DEPTH  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sb_empty = 1'b1;
    logic          sb_full = 1'b0;
    logic          sb_get_oldest;
    store_buffer_t sb_oldest_info = '0;
    logic          ld_req_valid = 1'b0;
    logic          wr_req_valid;
    store_buffer_t wr_req_info;
    logic          wr_req_ready = 1'b0;
    logic          wr_rsp_valid = 1'b0;
    logic          wr_rsp_miss = 1'b0;
    logic          fill_done = 1'b0;
    logic          drain_busy;
    logic [15:0]   drain_count;

    int checks = 0;
    int failures = 0;

    store_buffer_t sb_q[$];
    store_buffer_t exp_q[$];
    bit seen_get = 0;
    bit seen_accept = 0;

    int ld_mode = 3;
    int ld_pct = 0;
    int push_pct = 0;
    int push_now = 0;
    int ready_pct = 100;
    int stall_target = 0;
    int stall_cnt = 0;
    bit miss_next = 0;
    int miss_pct = 0;
    int fill_lo = 0;
    int fill_hi = 0;
    int rsp_hi = 0;
    bit spur_en = 0;
    bit force_fill = 0;
    int phase_cyc = 0;

    bit rsp_pend = 0;
    int rsp_delay = 0;
    bit fill_pend = 0;
    int fill_delay = 0;

    bit          m_req = 0;
    bit          m_rsp = 0;
    bit          m_fill = 0;
    logic [15:0] m_count = 16'd0;
    int          quiet = 0;
    int          cyc = 0;
    int          first_get = 0;
    int          get_total = 0;
    int          accept_total = 0;
    bit          exp_get;

    store_buffer_drain #(.DRAIN_IDLE_CYCLES(IDLE_N)) dut (
        .clock(clock),
        .reset(reset),
        .sb_empty(sb_empty),
        .sb_full(sb_full),
        .sb_get_oldest(sb_get_oldest),
        .sb_oldest_info(sb_oldest_info),
        .ld_req_valid(ld_req_valid),
        .wr_req_valid(wr_req_valid),
        .wr_req_info(wr_req_info),
        .wr_req_ready(wr_req_ready),
        .wr_rsp_valid(wr_rsp_valid),
        .wr_rsp_miss(wr_rsp_miss),
        .fill_done(fill_done),
        .drain_busy(drain_busy),
        .drain_count(drain_count)
    );

    always #5 clock = ~clock;

    function automatic store_buffer_t rand_entry();
        store_buffer_t e;
        e.addr    = $urandom;
        e.data    = $urandom;
        e.byte_en = 4'($urandom);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of environment: store buffer contents, load traffic, dcache ready/response/fill.
    task automatic applyStimulus(input bit do_reset);
        store_buffer_t e;
        bit just_missed;
        @(posedge clock);
        #1;
        just_missed  = 0;
        wr_rsp_valid = 1'b0;
        wr_rsp_miss  = 1'($urandom_range(1, 0));
        fill_done    = 1'b0;
        if (do_reset) begin
            reset = 1'b1;
            sb_q.delete();
            exp_q.delete();
            seen_get = 0;
            seen_accept = 0;
            rsp_pend = 0;
            fill_pend = 0;
            stall_cnt = 0;
            sb_empty = 1'b0;
            sb_full = 1'b1;
            sb_oldest_info = rand_entry();
            ld_req_valid = 1'($urandom_range(1, 0));
            wr_req_ready = 1'($urandom_range(1, 0));
        end else begin
            reset = 1'b0;
            if (seen_get) begin
                seen_get = 0;
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
            if (sb_q.size() < DEPTH && (push_now > 0 || $urandom_range(99, 0) < push_pct)) begin
                e = rand_entry();
                sb_q.push_back(e);
                exp_q.push_back(e);
                if (push_now > 0) push_now--;
            end
            sb_empty = (sb_q.size() == 0);
            sb_full  = (sb_q.size() == DEPTH);
            sb_oldest_info = sb_empty ? rand_entry() : sb_q[0];
            case (ld_mode)
                0: ld_req_valid = ($urandom_range(99, 0) < ld_pct);
                1: ld_req_valid = ((phase_cyc % 3) == 0);
                2: ld_req_valid = 1'b1;
                default: ld_req_valid = 1'b0;
            endcase
            phase_cyc++;
            if (wr_req_valid) begin
                if (stall_target > 0) begin
                    if (stall_cnt < stall_target) begin
                        wr_req_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        wr_req_ready = 1'b1;
                        stall_cnt = 0;
                    end
                end else begin
                    wr_req_ready = ($urandom_range(99, 0) < ready_pct);
                end
            end else begin
                wr_req_ready = 1'($urandom_range(1, 0));
            end
            if (seen_accept) begin
                seen_accept = 0;
                rsp_pend = 1;
                rsp_delay = $urandom_range(rsp_hi, 0);
            end
            if (rsp_pend) begin
                if (rsp_delay == 0) begin
                    rsp_pend = 0;
                    wr_rsp_valid = 1'b1;
                    wr_rsp_miss = miss_next || ($urandom_range(99, 0) < miss_pct);
                    miss_next = 0;
                    if (wr_rsp_miss) begin
                        fill_pend = 1;
                        fill_delay = $urandom_range(fill_hi, fill_lo);
                        just_missed = 1;
                    end
                end else begin
                    rsp_delay--;
                end
            end else if (spur_en && wr_req_valid && $urandom_range(3, 0) == 0) begin
                wr_rsp_valid = 1'b1;
            end
            if (fill_pend && !just_missed) begin
                if (fill_delay == 0) begin
                    fill_done = 1'b1;
                    fill_pend = 0;
                end else begin
                    fill_delay--;
                end
            end else if (!fill_pend && spur_en && $urandom_range(7, 0) == 0) begin
                fill_done = 1'b1;
            end
            if (force_fill) begin
                fill_done = 1'b1;
                force_fill = 0;
            end
        end
    endtask

    // Monitor: at most one store in flight, in buffer order; a drain may start only when
    // idle, non-empty, and either full or load-free for IDLE_N prior cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                checkOutput("get_during_reset", 128'(sb_get_oldest), 128'(0));
                m_req = 0;
                m_rsp = 0;
                m_fill = 0;
                m_count = 16'd0;
                quiet = 0;
                cyc = 0;
                first_get = 0;
            end else begin
                cyc++;
                exp_get = !(m_req || m_rsp || m_fill) && !sb_empty &&
                          (sb_full || (!ld_req_valid && quiet >= IDLE_N));
                checkOutput("sb_get_oldest", 128'(sb_get_oldest), 128'(exp_get));
                checkOutput("drain_busy", 128'(drain_busy), 128'(m_req || m_rsp || m_fill));
                checkOutput("wr_req_valid", 128'(wr_req_valid), 128'(m_req));
                checkOutput("drain_count", 128'(drain_count), 128'(m_count));
                if (m_req && wr_req_valid) begin
                    if (exp_q.size() > 0) begin
                        checkOutput("wr_req_info", 128'(wr_req_info), 128'(exp_q[0]));
                    end else begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL wr_req_info: got %0h expected no write at %0t", wr_req_info, $time);
                    end
                end
                if (sb_get_oldest) begin
                    get_total++;
                    if (first_get == 0) first_get = cyc;
                    seen_get = 1;
                end
                if (wr_req_valid && wr_req_ready) begin
                    accept_total++;
                    seen_accept = 1;
                end
                if (exp_get) begin
                    m_req = 1;
                end else if (m_req && wr_req_ready) begin
                    m_req = 0;
                    m_rsp = 1;
                end else if (m_rsp && wr_rsp_valid) begin
                    m_rsp = 0;
                    if (wr_rsp_miss) begin
                        m_fill = 1;
                    end else begin
                        m_count = m_count + 16'd1;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                end else if (m_fill && fill_done) begin
                    m_fill = 0;
                    m_req = 1;
                end
                if (ld_req_valid) quiet = 0;
                else if (quiet < IDLE_N) quiet++;
            end
        end
    end

    initial begin
        int g0;
        int a0;
        int budget;
        repeat (3) applyStimulus(1);

        // Idle drain of a single entry with no loads.
        ld_mode = 3; push_now = 1; ready_pct = 100; miss_pct = 0; spur_en = 0;
        repeat (20) applyStimulus(0);
        checkOutput("idle_drain_start_cycle", 128'(first_get), 128'(5));
        checkOutput("idle_drain_count", 128'(drain_count), 128'(1));

        // Loads every third cycle keep the drain from ever starting.
        spur_en = 1; ld_mode = 1; phase_cyc = 0; push_now = 2; g0 = get_total;
        repeat (40) applyStimulus(0);
        checkOutput("load_priority_gets", 128'(get_total - g0), 128'(0));

        // A full buffer forces drains despite continuous loads.
        ld_mode = 2; push_pct = 100; g0 = get_total;
        repeat (30) applyStimulus(0);
        checkOutput("forced_drain_seen", 128'((get_total - g0) > 0), 128'(1));

        // Miss with a fill ten cycles later, then drain the rest.
        ld_mode = 3; push_pct = 0; miss_next = 1; fill_lo = 9; fill_hi = 9;
        repeat (90) applyStimulus(0);
        checkOutput("miss_path_idle", 128'(drain_busy), 128'(0));
        checkOutput("miss_path_empty", 128'(sb_empty), 128'(1));

        // Seven cycles of backpressure, a single acceptance.
        stall_target = 7; push_now = 1; a0 = accept_total;
        repeat (30) applyStimulus(0);
        checkOutput("backpressure_accepts", 128'(accept_total - a0), 128'(1));
        stall_target = 0;

        // Reset while waiting for a fill.
        push_now = 1; miss_next = 1; fill_lo = 30; fill_hi = 30; budget = 0;
        while (!fill_pend && budget < 40) begin
            applyStimulus(0);
            budget++;
        end
        if (!fill_pend) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_fill_timeout: got no miss response expected one within 40 cycles");
        end
        applyStimulus(0);
        @(negedge clock);
        checkOutput("in_wait_fill_busy", 128'(drain_busy), 128'(1));
        applyStimulus(1);
        force_fill = 1;
        applyStimulus(0);
        @(negedge clock);
        checkOutput("post_reset_busy", 128'(drain_busy), 128'(0));
        checkOutput("post_reset_wr_valid", 128'(wr_req_valid), 128'(0));
        checkOutput("post_reset_count", 128'(drain_count), 128'(0));
        applyStimulus(0);
        @(negedge clock);
        checkOutput("fill_after_reset_ignored", 128'(drain_busy), 128'(0));

        // Randomized traffic with occasional resets.
        ld_mode = 0; ld_pct = 35; push_pct = 30; ready_pct = 60; miss_pct = 25;
        fill_lo = 0; fill_hi = 5; rsp_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(399, 0) == 0);
        end
        applyStimulus(0);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer_drain.md
STORE_BUFFER_DRAIN -- requirements
Module: store_buffer_drain

Interface
REQ-001 SHALL have parameter DRAIN_IDLE_CYCLES, default 4, meaning the number of consecutive cycles without a load request before a non-forced drain may start; legal range 0..15.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clock, input, 1 bit: the only clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sb_empty, input, 1 bit: store buffer holds no valid entry.
REQ-006 SHALL have port sb_full, input, 1 bit: every store buffer entry is valid.
REQ-007 SHALL have port sb_get_oldest, output, 1 bit: one-cycle pulse that retires the oldest store buffer entry.
REQ-008 SHALL have port sb_oldest_info, input, store_buffer_t: oldest entry, combinationally valid while sb_empty=0.
REQ-009 SHALL have port ld_req_valid, input, 1 bit: a pipeline load wants the dcache this cycle.
REQ-010 SHALL have port wr_req_valid, output, 1 bit: store write request to the dcache.
REQ-011 SHALL have port wr_req_info, output, store_buffer_t: payload of the write request.
REQ-012 SHALL have port wr_req_ready, input, 1 bit: dcache accepts the write request this cycle.
REQ-013 SHALL have port wr_rsp_valid, input, 1 bit: dcache write completion.
REQ-014 SHALL have port wr_rsp_miss, input, 1 bit: qualifies wr_rsp_valid; the line missed and a fill has started.
REQ-015 SHALL have port fill_done, input, 1 bit: the pending line fill has completed.
REQ-016 SHALL have port drain_busy, output, 1 bit: the FSM is not IDLE.
REQ-017 SHALL have port drain_count, output, 16 bits: number of completed stores, wrapping.

Function
REQ-018 SHALL implement the FSM states IDLE, REQ, WAIT_RSP and WAIT_FILL.
REQ-019 SHALL keep idle_cnt, a 4-bit counter:
- clears in any cycle with ld_req_valid=1;
- otherwise increments, saturating at DRAIN_IDLE_CYCLES.
REQ-020 SHALL start a drain from IDLE when:
- sb_empty=0, and
- either sb_full=1, or ld_req_valid=0 and idle_cnt>=DRAIN_IDLE_CYCLES.
REQ-021 SHALL, on drain start, in the same cycle:
- pulse sb_get_oldest;
- latch sb_oldest_info into the hold register;
- move to REQ next cycle.
REQ-022 SHALL force a drain on sb_full=1 regardless of ld_req_valid, giving full-buffer deadlock avoidance priority over loads.
REQ-023 SHALL assert sb_get_oldest only on drain start, never for two consecutive cycles, and never while sb_empty=1.
REQ-024 SHALL, in REQ:
- drive wr_req_valid=1 and wr_req_info=hold register, both stable until wr_req_ready=1;
- on acceptance, move to WAIT_RSP.
REQ-025 SHALL ignore wr_rsp_valid while in REQ; the earliest legal response is the cycle after acceptance.
REQ-026 SHALL, in WAIT_RSP:
- on wr_rsp_valid=1 and wr_rsp_miss=0, increment drain_count and go to IDLE;
- on wr_rsp_valid=1 and wr_rsp_miss=1, go to WAIT_FILL with the hold register unchanged.
REQ-027 SHALL ignore fill_done outside WAIT_FILL.
REQ-028 SHALL, in WAIT_FILL, return to REQ on fill_done=1 and reissue the identical wr_req_info; there is no retry limit.
REQ-029 SHALL allow a new drain to start at the earliest in the cycle after the return to IDLE, giving at most one store in flight.
REQ-030 SHALL drive drain_busy=1 in REQ, WAIT_RSP and WAIT_FILL.
REQ-031 SHALL wrap drain_count from 16'hFFFF to 16'h0000 without any flag.
REQ-032 SHALL keep wr_req_valid and sb_get_oldest mutually exclusive in every cycle.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set:
- state=IDLE, idle_cnt=0, hold register=0, drain_count=0;
- sb_get_oldest=0, wr_req_valid=0, drain_busy=0.
REQ-034 SHALL, on reset in any state, abandon the in-flight store without a response; the store buffer is reset by the same signal.
REQ-035 SHALL have reset take priority over every start, handshake and response event in the same cycle.

Verification
REQ-036 SHALL cover the idle drain:
- stimulus: DRAIN_IDLE_CYCLES=4, one entry, ld_req_valid=0 from reset release;
- response: sb_get_oldest pulses in the 5th cycle, wr_req_valid follows next cycle, wr_req_ready=1, hit response, drain_count=1.
REQ-037 SHALL cover load priority:
- stimulus: ld_req_valid toggles 1 every 3rd cycle, sb_empty=0, sb_full=0;
- response: sb_get_oldest never asserted.
REQ-038 SHALL cover the forced drain:
- stimulus: sb_full=1, ld_req_valid=1 continuously;
- response: sb_get_oldest pulses the next cycle from IDLE.
REQ-039 SHALL cover the miss path:
- stimulus: wr_rsp_miss=1, fill_done 10 cycles later;
- response: wr_req_valid reasserts the cycle after fill_done with identical wr_req_info, drain_count incremented only after the hit response.
REQ-040 SHALL cover backpressure:
- stimulus: wr_req_ready=0 for 7 cycles;
- response: wr_req_valid and wr_req_info stable for all 7 cycles, one acceptance.
REQ-041 SHALL cover reset in WAIT_FILL:
- stimulus: reset=1 for 1 cycle while in WAIT_FILL;
- response: next cycle drain_busy=0, wr_req_valid=0, drain_count=0, and fill_done ignored.
